mat_nxn_mult_seq: RTL and testbench
===================================

MAT_NXN_MULT_SEQ -- requirements
Module: mat_nxn_mult_seq

Interface
- REQ-001: Parameter WIDTH, default 8: bit width of each A/B matrix element.
- REQ-002: Parameter N, default 2, legal range 2..8: matrix dimension; the block computes the NxN product C = A x B.
- REQ-003: Parameter SIGNED, default 0: 0 = unsigned elements, 1 = two's-complement elements.
- REQ-004: Derived constant ACC_W = 2*WIDTH + clog2(N): width of each result element; ACC_W = 17 for the defaults.
- REQ-005: clk  input  1  single clock; all state updates on its rising edge.
- REQ-006: reset  input  1  reset, asynchronous, active-low; clears all state when low.
- REQ-007: A  input  N*N*WIDTH  packed matrix A, row-major, element (0,0) in the MSBs, element (N-1,N-1) in the LSBs.
- REQ-008: B  input  N*N*WIDTH  packed matrix B, same packing as A.
- REQ-009: in_valid  input  1  A/B operands present.
- REQ-010: in_ready  output  1  block can accept operands.
- REQ-011: Res  output  N*N*ACC_W  packed result C, same ordering as A, ACC_W bits per element.
- REQ-012: out_valid  output  1  Res holds a complete product.
- REQ-013: out_ready  input  1  consumer accepts Res.
- REQ-014: busy  output  1  high in every state except IDLE.

Function
- REQ-015: The FSM SHALL have exactly three states: IDLE, COMPUTE and DONE.
- REQ-016: IDLE: in_ready = 1, out_valid = 0.
- REQ-017: IDLE, in_valid = 1 on a rising edge: register A and B internally, clear all N*N accumulators, set k = 0, go to COMPUTE.
- REQ-018: COMPUTE, per cycle: for every (i,j) in parallel, acc[i][j] += Aq[i][k] * Bq[k][j], then k increments.
- REQ-019: COMPUTE with k = N-1: perform the final accumulation, go to DONE.
- REQ-020: COMPUTE therefore SHALL last exactly N cycles.
- REQ-021: Latency: out_valid SHALL rise N+1 rising edges after the accepting edge, counting the accepting edge itself as edge 1.
- REQ-022: DONE: out_valid = 1, in_ready = 0; Res SHALL be driven from the accumulators.
- REQ-023: DONE, out_ready = 1 on a rising edge: transfer completes, go to IDLE.
- REQ-024: DONE, out_ready = 0: hold state; Res stays bit-stable for any number of cycles.
- REQ-025: in_ready SHALL be 0 in COMPUTE and DONE.
- REQ-026: in_valid asserted outside IDLE SHALL be ignored, and A/B changes after acceptance SHALL have no effect on the result.
- REQ-027: After a DONE->IDLE transfer, in_ready SHALL be 1 in the next cycle; the minimum issue interval is N+2 cycles.
- REQ-028: SIGNED = 0: products and sums zero-extended to ACC_W.
- REQ-029: SIGNED = 1: operands and products sign-extended to ACC_W.
- REQ-030: ACC_W SHALL be wide enough that no overflow or wrap is possible for any operands; no saturation logic.
- REQ-031: Res SHALL be valid only while out_valid = 1; its value outside DONE is don't-care, except after reset (see REQ-032).

Reset
- REQ-032: While reset = 0, asynchronously: state = IDLE, k = 0, accumulators = 0, Res = 0, out_valid = 0, busy = 0.
- REQ-033: While reset = 0, in_ready SHALL be 0; it rises in the first cycle after reset deasserts.
- REQ-034: Reset asserted in COMPUTE or DONE SHALL abandon the operation with no output transfer; the next accepted operands compute from zeroed accumulators.

Verification
- REQ-035: Basic, N=2, WIDTH=8, unsigned: A=[1,2;3,4], B=[5,6;7,8], out_ready=1 -> out_valid on the 3rd edge after acceptance, Res = {17'd19, 17'd22, 17'd43, 17'd50}.
- REQ-036: Max values, N=2, unsigned: all elements 255 -> every Res element = 130050, no wrap.
- REQ-037: Signed, N=2, SIGNED=1: A=[-1,2;3,-4], B=[5,-6;7,8] -> Res = [9,22;-13,-50], each as 17-bit two's complement.
- REQ-038: Backpressure: hold out_ready=0 for 5 cycles in DONE and toggle A/B/in_valid meanwhile -> Res stable, in_ready=0; transfer happens on the first edge with out_ready=1.
- REQ-039: Reset mid-COMPUTE: drop reset at k=1 -> outputs zero immediately; a subsequent op with A=B=identity returns the identity matrix.
- REQ-040: N=4, WIDTH=4, two back-to-back ops with in_valid held high -> second accepted exactly one cycle after the first transfer; both results match a reference model.

Source files
------------

// File: rtl/mat_nxn_mult_seq_if.sv
// Operand/result handshake bundle for the sequential NxN matrix multiplier.
// The master drives operands and out_ready; the slave returns the product.
interface mat_nxn_mult_seq_if #(
    parameter int unsigned WIDTH = 8,
    parameter int unsigned N     = 2
) ();
    localparam int unsigned ACC_W = 2 * WIDTH + $clog2(N);

    logic [N*N*WIDTH-1:0] A;
    logic [N*N*WIDTH-1:0] B;
    logic                 in_valid;
    logic                 in_ready;
    logic [N*N*ACC_W-1:0] Res;
    logic                 out_valid;
    logic                 out_ready;
    logic                 busy;

    modport master (
        output A, B, in_valid, out_ready,
        input  in_ready, Res, out_valid, busy
    );

    modport slave (
        input  A, B, in_valid, out_ready,
        output in_ready, Res, out_valid, busy
    );
endinterface

// File: rtl/mat_nxn_mult_seq.sv
// Sequential NxN matrix multiplier: one inner-product term per cycle for all
// N*N result elements in parallel, N compute cycles per product.
module mat_nxn_mult_seq #(
    parameter int unsigned WIDTH  = 8,
    parameter int unsigned N      = 2,
    parameter int unsigned SIGNED = 0
) (
    input  logic               clk,
    input  logic               reset,
    mat_nxn_mult_seq_if.slave  bus
);
    localparam int unsigned ACC_W = 2 * WIDTH + $clog2(N);
    localparam int unsigned KW    = $clog2(N);
    localparam logic [KW-1:0] K_LAST = KW'(N - 1);

    typedef enum logic [1:0] {IDLE, COMPUTE, DONE} state_t;

    state_t          state;
    logic [KW-1:0]   k;
    logic            in_ready_q;
    logic            out_valid_q;
    logic            busy_q;
    logic            load_c;
    logic            step_c;

    logic [WIDTH-1:0] aq [N][N];
    logic [WIDTH-1:0] bq [N][N];

    // Widen an element to the accumulator width, sign- or zero-extending.
    function automatic logic [ACC_W-1:0] ext(input logic [WIDTH-1:0] v);
        if (SIGNED != 0) return ACC_W'($signed(v));
        return ACC_W'(v);
    endfunction

    assign load_c = (state == IDLE) && in_ready_q && bus.in_valid;
    assign step_c = (state == COMPUTE);

    assign bus.in_ready  = in_ready_q;
    assign bus.out_valid = out_valid_q;
    assign bus.busy      = busy_q;

    // Control FSM; handshake outputs are registered alongside the state.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state       <= IDLE;
            k           <= '0;
            in_ready_q  <= 1'b0;
            out_valid_q <= 1'b0;
            busy_q      <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    in_ready_q <= 1'b1;
                    if (load_c) begin
                        state      <= COMPUTE;
                        k          <= '0;
                        in_ready_q <= 1'b0;
                        busy_q     <= 1'b1;
                    end
                end
                COMPUTE: begin
                    k <= k + KW'(1);
                    if (k == K_LAST) begin
                        k           <= '0;
                        state       <= DONE;
                        out_valid_q <= 1'b1;
                    end
                end
                DONE: begin
                    if (bus.out_ready) begin
                        state       <= IDLE;
                        out_valid_q <= 1'b0;
                        busy_q      <= 1'b0;
                        in_ready_q  <= 1'b1;
                    end
                end
                default: begin
                    state       <= IDLE;
                    k           <= '0;
                    in_ready_q  <= 1'b0;
                    out_valid_q <= 1'b0;
                    busy_q      <= 1'b0;
                end
            endcase
        end
    end

    // Per-element operand capture and multiply-accumulate.
    for (genvar i = 0; i < N; i++) begin : g_row
        for (genvar j = 0; j < N; j++) begin : g_col
            localparam int unsigned E = (N * N - 1) - (i * N + j);

            logic [WIDTH-1:0] a_el;
            logic [WIDTH-1:0] b_el;
            logic [ACC_W-1:0] acc;
            logic [ACC_W-1:0] prod_c;

            assign aq[i][j] = a_el;
            assign bq[i][j] = b_el;
            assign prod_c   = ext(aq[i][k]) * ext(bq[k][j]);

            always_ff @(posedge clk or negedge reset) begin
                if (!reset) begin
                    a_el <= '0;
                    b_el <= '0;
                    acc  <= '0;
                end else if (load_c) begin
                    a_el <= bus.A[E*WIDTH +: WIDTH];
                    b_el <= bus.B[E*WIDTH +: WIDTH];
                    acc  <= '0;
                end else if (step_c) begin
                    acc  <= acc + prod_c;
                end
            end

            assign bus.Res[E*ACC_W +: ACC_W] = acc;
        end
    end
endmodule

// File: tb/tb_mat_nxn_mult_seq.sv
// Scoreboard bench for mat_nxn_mult_seq: unsigned N=2, signed N=2 and
// unsigned N=4/WIDTH=4 instances driven with directed operand sets.
module tb_mat_nxn_mult_seq;
    logic clk;
    logic reset;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    mat_nxn_mult_seq_if #(.WIDTH(8), .N(2)) u_bus ();
    mat_nxn_mult_seq_if #(.WIDTH(8), .N(2)) s_bus ();
    mat_nxn_mult_seq_if #(.WIDTH(4), .N(4)) q_bus ();

    mat_nxn_mult_seq #(.WIDTH(8), .N(2), .SIGNED(0)) u_dut (.clk(clk), .reset(reset), .bus(u_bus));
    mat_nxn_mult_seq #(.WIDTH(8), .N(2), .SIGNED(1)) s_dut (.clk(clk), .reset(reset), .bus(s_bus));
    mat_nxn_mult_seq #(.WIDTH(4), .N(4), .SIGNED(0)) q_dut (.clk(clk), .reset(reset), .bus(q_bus));

    int vectors     = 0;
    int miscompares = 0;

    logic [67:0]  exp_u [$];
    logic [67:0]  exp_s [$];
    logic [159:0] exp_q [$];

    task automatic chk(input string name, input logic [159:0] act, input logic [159:0] req);
        vectors++;
        if (act !== req) begin
            miscompares++;
            $display("FAIL %s: got %0h, required %0h", name, act, req);
        end
    endtask

    task automatic unexpected(input string name);
        vectors++;
        miscompares++;
        $display("FAIL %s: output transfer with no expected result queued", name);
    endtask

    // Reference product for the 4x4, 4-bit unsigned instance.
    function automatic logic [159:0] model4(input logic [63:0] a, input logic [63:0] b);
        logic [159:0] r;
        logic [9:0]   s;
        r = '0;
        for (int i = 0; i < 4; i++) begin
            for (int j = 0; j < 4; j++) begin
                s = '0;
                for (int kk = 0; kk < 4; kk++)
                    s = s + 10'(a[(15 - (i * 4 + kk)) * 4 +: 4]) * 10'(b[(15 - (kk * 4 + j)) * 4 +: 4]);
                r[(15 - (i * 4 + j)) * 10 +: 10] = s;
            end
        end
        return r;
    endfunction

    // Monitors: inputs only change on negedges, so negedge+1 sees the handshake
    // exactly as the next rising edge will.
    always begin
        @(negedge clk); #1;
        if (reset === 1'b1 && u_bus.out_valid === 1'b1 && u_bus.out_ready === 1'b1) begin
            if (exp_u.size() == 0) unexpected("u_res");
            else chk("u_res", 160'(u_bus.Res), 160'(exp_u.pop_front()));
        end
    end

    always begin
        @(negedge clk); #1;
        if (reset === 1'b1 && s_bus.out_valid === 1'b1 && s_bus.out_ready === 1'b1) begin
            if (exp_s.size() == 0) unexpected("s_res");
            else chk("s_res", 160'(s_bus.Res), 160'(exp_s.pop_front()));
        end
    end

    always begin
        @(negedge clk); #1;
        if (reset === 1'b1 && q_bus.out_valid === 1'b1 && q_bus.out_ready === 1'b1) begin
            if (exp_q.size() == 0) unexpected("q_res");
            else chk("q_res", q_bus.Res, exp_q.pop_front());
        end
    end

    function automatic logic get_valid(input int d);
        if (d == 0) return u_bus.out_valid;
        if (d == 1) return s_bus.out_valid;
        return q_bus.out_valid;
    endfunction

    task automatic wait_valid(input int d);
        int c;
        c = 0;
        while (c < 20 && get_valid(d) !== 1'b1) begin
            @(posedge clk); #1;
            c++;
        end
        chk($sformatf("valid_wait%0d", d), 160'(get_valid(d)), 160'(1));
    endtask

    // Present operands, expect acceptance on the next edge, then scramble A/B.
    task automatic issue_u(input logic [31:0] a, input logic [31:0] b,
                           input logic [67:0] e, input bit push);
        @(negedge clk);
        u_bus.A = a;
        u_bus.B = b;
        u_bus.in_valid = 1'b1;
        if (push) exp_u.push_back(e);
        @(posedge clk); #1;
        chk("u_accept_busy", 160'(u_bus.busy), 160'(1));
        chk("u_accept_rdy", 160'(u_bus.in_ready), 160'(0));
        @(negedge clk);
        u_bus.in_valid = 1'b0;
        u_bus.A = ~a;
        u_bus.B = ~b;
    endtask

    task automatic issue_s(input logic [31:0] a, input logic [31:0] b, input logic [67:0] e);
        @(negedge clk);
        s_bus.A = a;
        s_bus.B = b;
        s_bus.in_valid = 1'b1;
        exp_s.push_back(e);
        @(posedge clk);
        @(negedge clk);
        s_bus.in_valid = 1'b0;
        wait_valid(1);
        @(posedge clk); #1;
    endtask

    localparam logic [63:0] QA1 = 64'h0123_4567_89AB_CDEF;
    localparam logic [63:0] QB1 = 64'hFFFF_FFFF_FFFF_FFFF;
    localparam logic [63:0] QA2 = 64'h1000_0100_0010_0001;
    localparam logic [63:0] QB2 = 64'h3141_5926_5358_9793;
    localparam logic [67:0] BP_RES = {17'd8, 17'd2, 17'd4, 17'd16};

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish, got timeout, required completion");
        $fatal(1);
    end

    initial begin
        reset = 1'b0;
        u_bus.A = '0; u_bus.B = '0; u_bus.in_valid = 1'b0; u_bus.out_ready = 1'b0;
        s_bus.A = '0; s_bus.B = '0; s_bus.in_valid = 1'b0; s_bus.out_ready = 1'b0;
        q_bus.A = '0; q_bus.B = '0; q_bus.in_valid = 1'b0; q_bus.out_ready = 1'b0;

        // Reset state while reset is held low.
        #12;
        chk("rst_in_ready", 160'(u_bus.in_ready), 160'(0));
        chk("rst_out_valid", 160'(u_bus.out_valid), 160'(0));
        chk("rst_busy", 160'(u_bus.busy), 160'(0));
        chk("rst_res", 160'(u_bus.Res), 160'(0));
        chk("rst_res_q", q_bus.Res, 160'(0));
        @(negedge clk);
        reset = 1'b1;
        @(posedge clk); #1;
        chk("post_rst_rdy_u", 160'(u_bus.in_ready), 160'(1));
        chk("post_rst_rdy_q", 160'(q_bus.in_ready), 160'(1));

        // Basic product and latency: out_valid on the third edge from acceptance.
        u_bus.out_ready = 1'b1;
        issue_u({8'd1, 8'd2, 8'd3, 8'd4}, {8'd5, 8'd6, 8'd7, 8'd8},
                {17'd19, 17'd22, 17'd43, 17'd50}, 1'b1);
        @(posedge clk); #1;
        chk("lat_edge2", 160'(u_bus.out_valid), 160'(0));
        @(posedge clk); #1;
        chk("lat_edge3", 160'(u_bus.out_valid), 160'(1));
        chk("done_rdy", 160'(u_bus.in_ready), 160'(0));
        @(posedge clk); #1;
        chk("xfer_valid", 160'(u_bus.out_valid), 160'(0));
        chk("xfer_rdy", 160'(u_bus.in_ready), 160'(1));

        // Maximum operands: no wrap in 17 bits.
        issue_u({4{8'd255}}, {4{8'd255}}, {4{17'd130050}}, 1'b1);
        wait_valid(0);
        @(posedge clk); #1;

        // Backpressure: hold in DONE while operands and in_valid churn.
        @(negedge clk);
        u_bus.out_ready = 1'b0;
        issue_u({8'd2, 8'd0, 8'd1, 8'd3}, {8'd4, 8'd1, 8'd0, 8'd5}, BP_RES, 1'b1);
        wait_valid(0);
        for (int c = 0; c < 5; c++) begin
            @(negedge clk);
            u_bus.A = $urandom();
            u_bus.B = $urandom();
            u_bus.in_valid = ~u_bus.in_valid;
            @(posedge clk); #1;
            chk("bp_res", 160'(u_bus.Res), 160'(BP_RES));
            chk("bp_rdy", 160'(u_bus.in_ready), 160'(0));
            chk("bp_valid", 160'(u_bus.out_valid), 160'(1));
        end
        @(negedge clk);
        u_bus.in_valid = 1'b0;
        u_bus.out_ready = 1'b1;
        @(posedge clk); #1;
        chk("bp_xfer_valid", 160'(u_bus.out_valid), 160'(0));
        chk("bp_xfer_rdy", 160'(u_bus.in_ready), 160'(1));
        @(posedge clk); #1;
        chk("bp_idle_busy", 160'(u_bus.busy), 160'(0));

        // Reset at k=1 abandons the operation.
        issue_u({8'd1, 8'd2, 8'd3, 8'd4}, {8'd5, 8'd6, 8'd7, 8'd8}, '0, 1'b0);
        @(posedge clk);
        @(negedge clk);
        reset = 1'b0;
        #1;
        chk("midrst_valid", 160'(u_bus.out_valid), 160'(0));
        chk("midrst_busy", 160'(u_bus.busy), 160'(0));
        chk("midrst_rdy", 160'(u_bus.in_ready), 160'(0));
        chk("midrst_res", 160'(u_bus.Res), 160'(0));
        @(negedge clk);
        @(negedge clk);
        reset = 1'b1;
        @(posedge clk); #1;
        chk("midrst_rdy_back", 160'(u_bus.in_ready), 160'(1));
        issue_u({8'd1, 8'd0, 8'd0, 8'd1}, {8'd1, 8'd0, 8'd0, 8'd1},
                {17'd1, 17'd0, 17'd0, 17'd1}, 1'b1);
        wait_valid(0);
        @(posedge clk); #1;

        // Signed operands, including the most negative element value.
        s_bus.out_ready = 1'b1;
        issue_s({8'hFF, 8'd2, 8'd3, 8'hFC}, {8'd5, 8'hFA, 8'd7, 8'd8},
                {17'd9, 17'd22, 17'h1FFF3, 17'h1FFCE});
        issue_s({4{8'h80}}, {4{8'h80}}, {4{17'd32768}});

        // 4x4 back-to-back with in_valid held high.
        @(negedge clk);
        q_bus.out_ready = 1'b1;
        q_bus.A = QA1;
        q_bus.B = QB1;
        q_bus.in_valid = 1'b1;
        exp_q.push_back(model4(QA1, QB1));
        exp_q.push_back(model4(QA2, QB2));
        @(posedge clk); #1;
        chk("q_accept1", 160'(q_bus.busy), 160'(1));
        @(negedge clk);
        q_bus.A = QA2;
        q_bus.B = QB2;
        repeat (3) @(posedge clk);
        #1;
        chk("q_not_yet", 160'(q_bus.out_valid), 160'(0));
        @(posedge clk); #1;
        chk("q_lat", 160'(q_bus.out_valid), 160'(1));
        @(posedge clk); #1;
        chk("q_xfer_busy", 160'(q_bus.busy), 160'(0));
        chk("q_xfer_rdy", 160'(q_bus.in_ready), 160'(1));
        @(posedge clk); #1;
        chk("q_accept2", 160'(q_bus.busy), 160'(1));
        @(negedge clk);
        q_bus.in_valid = 1'b0;
        wait_valid(2);
        repeat (3) @(posedge clk);
        #1;

        chk("u_queue_empty", 160'(exp_u.size()), 160'(0));
        chk("s_queue_empty", 160'(exp_s.size()), 160'(0));
        chk("q_queue_empty", 160'(exp_q.size()), 160'(0));

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
